// File: rtl/fifo_pkg.sv
// Shared defaults for the FIFO controller family.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_WIDTH   = 8;
  localparam int unsigned FIFO_ADDR_WIDTH   = 4;
  localparam int unsigned FIFO_AFULL_LEVEL  = 12;
  localparam int unsigned FIFO_AEMPTY_LEVEL = 4;

endpackage

// File: rtl/fifo_ctrl.sv
// FIFO controller driving an external registered dual-port memory.
// Holds DEPTH words in memory plus one word on the output register stage.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = FIFO_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH   = FIFO_ADDR_WIDTH,
  parameter int unsigned AFULL_LEVEL  = FIFO_AFULL_LEVEL,
  parameter int unsigned AEMPTY_LEVEL = FIFO_AEMPTY_LEVEL
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH:0]   mem_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AFULL_C  = AFULL_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = AEMPTY_LEVEL[ADDR_WIDTH:0];

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic                m_valid_q, m_valid_d;
  logic                wr_fire;
  logic                rd_issue;

  // Status flags and handshakes, all decoded from registered state.
  always_comb begin
    full         = (count_q == DEPTH_C);
    empty        = (count_q == '0);
    almost_full  = (count_q >= AFULL_C);
    almost_empty = (count_q <= AEMPTY_C);
    s_ready      = !full;
    // rstn gate keeps the write strobe quiet while reset holds s_ready high.
    wr_fire      = s_valid && !full && rstn;
    rd_issue     = !empty && (!m_valid_q || m_ready);
  end

  // Memory port drive and downstream data passthrough.
  always_comb begin
    mem_write_en   = wr_fire;
    mem_write_addr = wr_ptr_q[ADDR_WIDTH-1:0];
    mem_write_data = s_data;
    mem_read_en    = rd_issue;
    mem_read_addr  = rd_ptr_q[ADDR_WIDTH-1:0];
    m_valid        = m_valid_q;
    m_data         = mem_read_data;
    mem_count      = count_q;
  end

  // Next-state for pointers, occupancy and output-valid.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    m_valid_d = rd_issue || (m_valid_q && !m_ready);
    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_issue) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_fire, rd_issue})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      m_valid_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      m_valid_q <= m_valid_d;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: registered memory stand-in, queue-based reference
// model checked every negedge, plus directed literal expectations.
module tb_fifo_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic          clk;
  logic          rstn;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          mem_write_en;
  logic [AW-1:0] mem_write_addr;
  logic [DW-1:0] mem_write_data;
  logic          mem_read_en;
  logic [AW-1:0] mem_read_addr;
  logic [DW-1:0] mem_read_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [AW:0]   mem_count;
  logic          full, empty, almost_full, almost_empty;

  int unsigned checks = 0;
  int unsigned errors = 0;

  fifo_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AFULL_LEVEL(12),
    .AEMPTY_LEVEL(4)
  ) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data),
    .mem_read_en(mem_read_en), .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .mem_count(mem_count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory stand-in: registered read, holds output while read strobe is low.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_write_addr] <= mem_write_data;
    if (mem_read_en)  mem_read_data <= mem[mem_read_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words held in memory as a queue, plus one output slot.
  logic [DW-1:0] mq[$];
  logic          ov = 1'b0;
  logic [DW-1:0] ow = '0;
  int unsigned   wcnt = 0, rcnt = 0;

  always @(negedge clk) begin
    int unsigned n;
    logic e_full, e_wr, e_rd;
    if (!rstn) begin
      chk("rst_wen", {31'd0, mem_write_en}, 0);
      chk("rst_ren", {31'd0, mem_read_en}, 0);
      chk("rst_mvalid", {31'd0, m_valid}, 0);
      chk("rst_count", {27'd0, mem_count}, 0);
      chk("rst_flags", {27'd0, empty, almost_empty, full, almost_full, s_ready}, 32'b11001);
      mq.delete();
      ov = 1'b0;
      wcnt = 0;
      rcnt = 0;
    end else begin
      n      = mq.size();
      e_full = (n == DEPTH);
      e_wr   = s_valid && !e_full;
      e_rd   = (n > 0) && (!ov || m_ready);
      chk("count", {27'd0, mem_count}, n);
      chk("full", {31'd0, full}, {31'd0, e_full});
      chk("empty", {31'd0, empty}, {31'd0, n == 0});
      chk("afull", {31'd0, almost_full}, {31'd0, n >= 12});
      chk("aempty", {31'd0, almost_empty}, {31'd0, n <= 4});
      chk("s_ready", {31'd0, s_ready}, {31'd0, !e_full});
      chk("wen", {31'd0, mem_write_en}, {31'd0, e_wr});
      chk("ren", {31'd0, mem_read_en}, {31'd0, e_rd});
      chk("m_valid", {31'd0, m_valid}, {31'd0, ov});
      if (ov) chk("m_data", {24'd0, m_data}, {24'd0, ow});
      if (e_wr) begin
        chk("waddr", {28'd0, mem_write_addr}, wcnt % DEPTH);
        chk("wdata", {24'd0, mem_write_data}, {24'd0, s_data});
      end
      if (e_rd) chk("raddr", {28'd0, mem_read_addr}, rcnt % DEPTH);
      if (ov && m_ready && !e_rd) ov = 1'b0;
      if (e_rd) begin
        ow = mq.pop_front();
        ov = 1'b1;
        rcnt++;
      end
      if (e_wr) begin
        mq.push_back(s_data);
        wcnt++;
      end
    end
  end

  // Sink: every word the downstream side actually accepted.
  logic [DW-1:0] sink[$];
  always @(negedge clk) begin
    if (rstn && m_valid && m_ready) sink.push_back(m_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  int unsigned lv [5] = '{3, 4, 5, 11, 12};
  logic        ae [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        af [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int unsigned acc;
    rstn = 1'b0; s_valid = 1'b1; s_data = 8'h99; m_ready = 1'b0;

    // Reset with s_valid held: no write until release, first write at 0.
    repeat (3) begin
      @(negedge clk);
      chk("r040_no_write", {31'd0, mem_write_en}, 0);
    end
    step();
    rstn = 1'b1;
    @(negedge clk);
    chk("r040_first_wen", {31'd0, mem_write_en}, 1);
    chk("r040_first_addr", {28'd0, mem_write_addr}, 0);
    step();
    s_valid = 1'b0; m_ready = 1'b1;
    repeat (5) step();

    // Three words, m_ready high: 0x11 on m_data two cycles after handshake.
    do_reset();
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 8'h11; step();
    s_data = 8'h22; step();
    s_data = 8'h33;
    @(negedge clk);
    chk("r041_c2_valid", {31'd0, m_valid}, 1);
    chk("r041_c2_data", {24'd0, m_data}, 32'h11);
    step();
    s_valid = 1'b0;
    @(negedge clk);
    chk("r041_c3_data", {24'd0, m_data}, 32'h22);
    step();
    @(negedge clk);
    chk("r041_c4_data", {24'd0, m_data}, 32'h33);
    step();
    @(negedge clk);
    chk("r041_end_empty", {31'd0, empty}, 1);
    chk("r041_end_valid", {31'd0, m_valid}, 0);
    step();

    // Fill with 17 words, m_ready low, then single-cycle m_ready pulse.
    do_reset();
    sink.delete();
    m_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      s_valid = 1'b1; s_data = 8'(i); step();
    end
    s_data = 8'h11;
    @(negedge clk);
    chk("r042_count", {27'd0, mem_count}, 16);
    chk("r042_full", {31'd0, full}, 1);
    chk("r042_s_ready", {31'd0, s_ready}, 0);
    chk("r042_m_data", {24'd0, m_data}, 0);
    chk("r042_stall", {31'd0, mem_write_en}, 0);
    step();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    @(negedge clk);
    chk("r043_next_data", {24'd0, m_data}, 1);
    chk("r043_s_ready", {31'd0, s_ready}, 1);
    chk("r043_write", {31'd0, mem_write_en}, 1);
    step();
    s_valid = 1'b0;
    @(negedge clk);
    chk("r043_refull", {31'd0, full}, 1);
    step();
    m_ready = 1'b1;
    repeat (25) step();
    chk("r043_sink_len", sink.size(), 18);
    for (int i = 0; i < 18 && i < sink.size(); i++)
      chk("r043_sink_word", {24'd0, sink[i]}, i);

    // Occupancy sweep for the almost flags.
    do_reset();
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'hF0; step();
    s_valid = 1'b0;
    repeat (3) step();
    for (int k = 1; k <= 12; k++) begin
      s_valid = 1'b1; s_data = 8'(k); step();
      s_valid = 1'b0;
      @(negedge clk);
      chk("r045_count", {27'd0, mem_count}, k);
      for (int j = 0; j < 5; j++) begin
        if (k == lv[j]) begin
          chk("r045_aempty", {31'd0, almost_empty}, {31'd0, ae[j]});
          chk("r045_afull", {31'd0, almost_full}, {31'd0, af[j]});
        end
      end
      step();
    end

    // Reset mid-transfer discards stored words.
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 8'(8'hA0 + i); step();
    end
    #2 rstn = 1'b0;
    step();
    s_valid = 1'b0;
    step();
    rstn = 1'b1;
    sink.delete();
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 8'h55; step();
    s_valid = 1'b0;
    repeat (6) step();
    chk("r036_sink_len", sink.size(), 1);
    if (sink.size() > 0) chk("r036_sink_word", {24'd0, sink[0]}, 32'h55);

    // Random flow control, 40 words, pointers wrap past 2*DEPTH.
    sink.delete();
    acc = 0;
    for (int cyc = 0; cyc < 2000 && acc < 40; cyc++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 8'(acc * 7 + 3);
      m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (s_valid && s_ready) acc++;
      step();
    end
    chk("r044_accepted", acc, 40);
    s_valid = 1'b0; m_ready = 1'b1;
    repeat (40) step();
    chk("r044_sink_len", sink.size(), 40);
    for (int i = 0; i < 40 && i < sink.size(); i++)
      chk("r044_order", {24'd0, sink[i]}, {24'd0, 8'(i * 7 + 3)});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: word width.
REQ-002 Parameter ADDR_WIDTH, default 4: memory depth is 2^ADDR_WIDTH (DEPTH).
REQ-003 Parameter AFULL_LEVEL, default 12: almost_full asserts when mem_count >= AFULL_LEVEL.
REQ-004 Parameter AEMPTY_LEVEL, default 4: almost_empty asserts when mem_count <= AEMPTY_LEVEL.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rstn  in  1  reset, asynchronous, active-low.
REQ-007 s_valid  in  1  upstream word available.
REQ-008 s_ready  out  1  controller accepts a word this cycle.
REQ-009 s_data  in  DATA_WIDTH  upstream word.
REQ-010 mem_write_en  out  1  memory write strobe.
REQ-011 mem_write_addr  out  ADDR_WIDTH  memory write address.
REQ-012 mem_write_data  out  DATA_WIDTH  memory write data, equal to s_data.
REQ-013 mem_read_en  out  1  memory read strobe; the memory returns data 1 cycle later and holds it while the strobe is low.
REQ-014 mem_read_addr  out  ADDR_WIDTH  memory read address.
REQ-015 mem_read_data  in  DATA_WIDTH  registered memory output.
REQ-016 m_valid  out  1  downstream word valid.
REQ-017 m_ready  in  1  downstream accepts.
REQ-018 m_data  out  DATA_WIDTH  downstream word, equal to mem_read_data.
REQ-019 mem_count  out  ADDR_WIDTH+1  words held in memory, excluding any word presented on m_data.
REQ-020 full, empty, almost_full, almost_empty  out  1 each  status flags derived from mem_count.

Function
REQ-021 Write pointer wr_ptr and read pointer rd_ptr are ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits drive the memory addresses; both wrap modulo 2^(ADDR_WIDTH+1).
REQ-022 full = (mem_count == DEPTH); empty = (mem_count == 0); s_ready = !full, combinational from registered state.
REQ-023 Write: s_valid && s_ready -> mem_write_en=1 in the same cycle at wr_ptr; wr_ptr increments at the clock edge.
REQ-024 Read issue: rd_issue = !empty && (!m_valid || m_ready); mem_read_en = rd_issue at rd_ptr; rd_ptr increments at the clock edge.
REQ-025 m_valid is registered: m_valid <= rd_issue || (m_valid && !m_ready).
REQ-026 While m_valid && !m_ready, mem_read_en = 0, so m_data stays stable.
REQ-027 mem_count <= mem_count + write - rd_issue; a simultaneous write and read leaves mem_count unchanged.
REQ-028 Latency on an empty FIFO:
- s handshake in cycle 0;
- mem_read_en in cycle 1;
- m_valid in cycle 2.
REQ-029 Same-address hazard is impossible: a read at address A is issued only when mem_count > 0, and a write in the same cycle targets wr_ptr, never rd_ptr.
REQ-030 Total buffering is DEPTH+1 words: DEPTH in memory plus 1 on the output.
REQ-031 Full boundary: with full=1 and m_ready=1, a read is issued, full drops after the edge, and s_ready is 1 the following cycle.
REQ-032 Empty boundary: with empty=1, mem_read_en = 0 regardless of m_ready.
REQ-033 almost_full and almost_empty are combinational from mem_count, with no hysteresis.

Reset
REQ-034 While rstn = 0, the following SHALL be 0: wr_ptr, rd_ptr, mem_count, m_valid, mem_write_en, mem_read_en.
REQ-035 Flag values during reset SHALL be: empty = 1, almost_empty = 1, full = 0, almost_full = 0, s_ready = 1.
REQ-036 Reset asserted mid-transfer SHALL discard all stored words; words written before reset are never presented after reset.
REQ-037 Reset deassertion SHALL be synchronised by the integrator; the block introduces no extra reset latency.

Structure
REQ-038 Shared package fifo_pkg SHALL hold the default DATA_WIDTH, ADDR_WIDTH, AFULL_LEVEL and AEMPTY_LEVEL constants.
REQ-039 fifo_ctrl contains no sub-module; it is paired with the team's dual_port_memory in a separate fifo_top wrapper.

Verification
REQ-040 Reset with s_valid=1 held -> no mem_write_en until rstn=1; first write at addr 0.
REQ-041 Write 0x11, 0x22, 0x33 with m_ready=1 -> m_data 0x11 on cycle 2, then 0x22 and 0x33 on consecutive cycles; empty=1 at end.
REQ-042 Write 17 words 0x00-0x10 with m_ready=0 -> 1st word on m_data, mem_count=16, full=1, s_ready=0; 18th word stalled.
REQ-043 At full, pulse m_ready for 1 cycle -> 1 word out, s_ready=1 next cycle, no data loss or duplication.
REQ-044 Wrap-around: stream 40 words with random s_valid/m_ready -> output order equals input order, pointers wrap, and the scoreboard matches.
REQ-045 mem_count sweep 3, 4, 5, 11, 12 -> almost_empty = 1, 1, 0, 0, 0; almost_full = 0, 0, 0, 0, 1.
